// File: rtl/temp_scan_sched.sv
// temp_scan_sched: scan scheduler/supervisor for a DS18B20 1-wire temperature engine
// Ports: clk, rst_n (sync, active low), enable (periodic scan), req (on-demand scan),
//        eng_start/eng_rst/eng_done/eng_data (1-wire engine handshake, 72-bit scratchpad),
//        busy, temp_raw, temp_valid, new_sample, crc_err, timeout_err, sample_cnt (telemetry).
module temp_scan_sched #(
  parameter int FCLK         = 125,
  parameter int PERIOD_MS    = 1000,
  parameter int TIMEOUT_MS   = 1000,
  parameter int RETRY_GAP_US = 1000,
  parameter int MAX_RETRY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        req,
  output logic        eng_start,
  output logic        eng_rst,
  input  logic        eng_done,
  input  logic [71:0] eng_data,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic        temp_valid,
  output logic        new_sample,
  output logic        crc_err,
  output logic        timeout_err,
  output logic [15:0] sample_cnt
);
  typedef enum logic [2:0] {IDLE, START, WAIT, CHECK, GOOD, FAIL, GAP} state_t;
  localparam logic [15:0] US_LAST  = 16'(FCLK - 1);
  localparam logic [15:0] PER_LAST = 16'(PERIOD_MS - 1);
  // tmr restarts at 0 on every state entry and outputs are registered one cycle
  // after the state, so the -2 makes eng_start->eng_rst and GAP entry->eng_start
  // land exactly on TIMEOUT and RETRY_GAP clock counts.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_MS * 1000 * FCLK - 2);
  localparam logic [31:0] GAP_LAST = 32'(RETRY_GAP_US * FCLK - 2);
  localparam logic [7:0]  MAX_R    = 8'(MAX_RETRY);
  state_t      state_q, state_d;
  logic [15:0] us_q, us_d, per_q, per_d;
  logic [9:0]  ms_q, ms_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  retry_q, retry_d, crc_q, crc_d;
  logic [71:0] dat_q, dat_d;
  logic        pend_q, pend_d, to_q, to_d;
  logic        us_tick, ms_tick, per_hit;
  logic        eng_start_q, eng_start_d, eng_rst_q, eng_rst_d, busy_q, busy_d;
  logic [15:0] temp_raw_q, temp_raw_d, sample_cnt_q, sample_cnt_d;
  logic        temp_valid_q, temp_valid_d, new_sample_q, new_sample_d;
  logic        crc_err_q, crc_err_d, timeout_err_q, timeout_err_d;
  assign eng_start   = eng_start_q;
  assign eng_rst     = eng_rst_q;
  assign busy        = busy_q;
  assign temp_raw    = temp_raw_q;
  assign temp_valid  = temp_valid_q;
  assign new_sample  = new_sample_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = timeout_err_q;
  assign sample_cnt  = sample_cnt_q;
  always_comb begin
    us_tick       = us_q == US_LAST;
    ms_tick       = us_tick && ms_q == 10'd999;
    per_hit       = enable && ms_tick && per_q == PER_LAST;
    us_d          = us_tick ? 16'd0 : us_q + 16'd1;
    ms_d          = ms_tick ? 10'd0 : ms_q + {9'd0, us_tick};
    per_d         = (!enable || per_hit) ? 16'd0 : per_q + {15'd0, ms_tick};
    pend_d        = req || per_hit || (pend_q && state_q != START);
    state_d       = state_q;
    retry_d       = retry_q;
    to_d          = to_q;
    dat_d         = dat_q;
    crc_d         = crc_q;
    temp_raw_d    = temp_raw_q;
    temp_valid_d  = temp_valid_q;
    sample_cnt_d  = sample_cnt_q;
    crc_err_d     = crc_err_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE:  state_d = pend_q ? START : IDLE;
      START: state_d = WAIT;
      WAIT:
        if (eng_done) begin
          state_d = CHECK;
          dat_d   = eng_data;
          crc_d   = 8'h00;
        end else if (tmr_q == TMO_LAST) begin
          state_d = FAIL;
          to_d    = 1'b1;
        end
      CHECK:
        // 64 rotations of the payload feed the CRC LSB first and leave it unchanged
        if (tmr_q < 32'd64) begin
          crc_d       = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ dat_q[0]) ? 8'h8C : 8'h00);
          dat_d[63:0] = {dat_q[0], dat_q[63:1]};
        end else begin
          state_d = (crc_q == dat_q[71:64] && dat_q[63:0] != 64'd0) ? GOOD : FAIL;
          to_d    = 1'b0;
        end
      GOOD: begin
        temp_raw_d    = dat_q[15:0];
        temp_valid_d  = 1'b1;
        sample_cnt_d  = sample_cnt_q + 16'd1;
        crc_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        retry_d       = 8'd0;
        state_d       = IDLE;
      end
      FAIL:
        if (retry_q < MAX_R) begin
          retry_d = retry_q + 8'd1;
          state_d = GAP;
        end else begin
          crc_err_d     = !to_q;
          timeout_err_d = to_q;
          retry_d       = 8'd0;
          state_d       = IDLE;
        end
      GAP:     state_d = tmr_q == GAP_LAST ? START : GAP;
      default: state_d = IDLE;
    endcase
    tmr_d        = (state_d != state_q) ? 32'd0 : tmr_q + 32'd1;
    eng_start_d  = state_q == START;
    eng_rst_d    = state_q == FAIL && to_q;
    new_sample_d = state_q == GOOD;
    busy_d       = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      us_q          <= '0;
      ms_q          <= '0;
      per_q         <= '0;
      tmr_q         <= '0;
      retry_q       <= '0;
      crc_q         <= '0;
      dat_q         <= '0;
      pend_q        <= 1'b0;
      to_q          <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      temp_raw_q    <= '0;
      temp_valid_q  <= 1'b0;
      new_sample_q  <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      sample_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      us_q          <= us_d;
      ms_q          <= ms_d;
      per_q         <= per_d;
      tmr_q         <= tmr_d;
      retry_q       <= retry_d;
      crc_q         <= crc_d;
      dat_q         <= dat_d;
      pend_q        <= pend_d;
      to_q          <= to_d;
      eng_start_q   <= eng_start_d;
      eng_rst_q     <= eng_rst_d;
      busy_q        <= busy_d;
      temp_raw_q    <= temp_raw_d;
      temp_valid_q  <= temp_valid_d;
      new_sample_q  <= new_sample_d;
      crc_err_q     <= crc_err_d;
      timeout_err_q <= timeout_err_d;
      sample_cnt_q  <= sample_cnt_d;
    end
  end
endmodule

// File: tb/tb_temp_scan_sched.sv
// tb_temp_scan_sched: directed self-checking bench for temp_scan_sched
module tb_temp_scan_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        req = 1'b0;
  logic        eng_done = 1'b0;
  logic [71:0] eng_data = '0;
  logic        eng_start, eng_rst, busy, temp_valid, new_sample, crc_err, timeout_err;
  logic [15:0] temp_raw, sample_cnt;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    logic [71:0] data;
    bit          good;
    logic [15:0] temp;
    logic [15:0] cnt;
    bit          crc_e;
  } vec_t;
  vec_t tv[3];
  temp_scan_sched #(
    .FCLK(4), .PERIOD_MS(2), .TIMEOUT_MS(1), .RETRY_GAP_US(3), .MAX_RETRY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .eng_start(eng_start), .eng_rst(eng_rst), .eng_done(eng_done), .eng_data(eng_data),
    .busy(busy), .temp_raw(temp_raw), .temp_valid(temp_valid), .new_sample(new_sample),
    .crc_err(crc_err), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 64; i++) c = {1'b0, c[7:1]} ^ ((c[0] ^ d[i]) ? 8'h8C : 8'h00);
    return c;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask
  // sel: 0 = eng_start, 1 = new_sample, 2 = eng_rst; n = clocks until seen (max if never)
  task automatic wait_sig(input int sel, input int max, output int n, output bit hit);
    n = 0;
    hit = 1'b0;
    while (!hit && n < max) begin
      tick();
      n++;
      hit = sel == 0 ? eng_start : sel == 1 ? new_sample : eng_rst;
    end
  endtask
  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask
  task automatic send_done(input logic [71:0] d);
    eng_data = d;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_data = '0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, cnt;
    bit hit;
    logic [63:0] p2;
    logic [71:0] v1, v2, vbad;
    v1   = 72'h1C_10_0C_FF_7F_46_4B_05_50;
    vbad = 72'h1D_10_0C_FF_7F_46_4B_05_50;
    p2   = 64'h10_0F_FF_7F_46_4B_01_91;
    v2   = {crc8(p2), p2};
    tv[0] = '{v2, 1'b1, 16'h0191, 16'd2, 1'b0};
    tv[1] = '{vbad, 1'b0, 16'h0191, 16'd2, 1'b1};
    tv[2] = '{72'd0, 1'b0, 16'h0191, 16'd2, 1'b1};
    repeat (3) tick();
    check("rst_flags", {eng_rst, eng_start, busy, temp_valid, new_sample, crc_err, timeout_err}, 32'b1000000);
    check("rst_temp", temp_raw, 0);
    check("rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    check("eng_rst_release", eng_rst, 0);
    wait_sig(0, 9000, n, hit);
    check_rng("period_start", n + 1, 8000, 8004);
    check("busy_scan", busy, 1);
    enable = 1'b0;
    tick();
    check("start_pulse_width", eng_start, 0);
    send_done(v1);
    wait_sig(1, 100, n, hit);
    check("good_latency", n, 66);
    check("t1_temp", temp_raw, 16'h0550);
    check("t1_cnt", sample_cnt, 1);
    check("t1_valid", temp_valid, 1);
    check("t1_idle", busy, 0);
    tick();
    check("new_pulse_width", new_sample, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      wait_sig(0, 20, n, hit);
      check($sformatf("v%0d_start", i), hit, 1);
      send_done(tv[i].data);
      if (tv[i].good) begin
        wait_sig(1, 100, n, hit);
        check($sformatf("v%0d_latency", i), n, 66);
      end else begin
        wait_sig(0, 200, n, hit);
        check($sformatf("v%0d_retry_gap", i), n, 78);
        send_done(tv[i].data);
        cnt = 0;
        repeat (100) begin
          tick();
          if (new_sample) cnt++;
        end
        check($sformatf("v%0d_no_new", i), cnt, 0);
      end
      repeat (5) tick();
      check($sformatf("v%0d_temp", i), temp_raw, tv[i].temp);
      check($sformatf("v%0d_valid", i), temp_valid, 1);
      check($sformatf("v%0d_cnt", i), sample_cnt, tv[i].cnt);
      check($sformatf("v%0d_crc_err", i), crc_err, tv[i].crc_e);
      check($sformatf("v%0d_to_err", i), timeout_err, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
    end
    pulse_req();
    wait_sig(0, 20, n, hit);
    wait_sig(2, 5000, n, hit);
    check("timeout1_clks", n, 4000);
    tick();
    check("eng_rst_width", eng_rst, 0);
    wait_sig(0, 100, n, hit);
    check("timeout_retry_gap", n, 11);
    wait_sig(2, 5000, n, hit);
    check("timeout2_clks", n, 4000);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_crc_clr", crc_err, 0);
    check("timeout_temp_kept", temp_raw, 16'h0191);
    check("timeout_valid_kept", temp_valid, 1);
    pulse_req();
    wait_sig(0, 20, n, hit);
    send_done(v1);
    wait_sig(1, 100, n, hit);
    check("t3_good_latency", n, 66);
    check("t3_to_err_clr", timeout_err, 0);
    check("t3_temp", temp_raw, 16'h0550);
    check("t3_cnt", sample_cnt, 3);
    pulse_req();
    wait_sig(0, 20, n, hit);
    repeat (3) begin
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
    end
    send_done(v1);
    wait_sig(1, 100, n, hit);
    check("t4_first_new", hit, 1);
    wait_sig(0, 50, n, hit);
    check("t4_extra_scan", hit, 1);
    send_done(v1);
    wait_sig(1, 100, n, hit);
    check("t4_second_new", hit, 1);
    cnt = 0;
    repeat (12000) begin
      tick();
      if (eng_start) cnt++;
    end
    check("t4_no_more_starts", cnt, 0);
    check("t4_cnt", sample_cnt, 5);
    eng_data = v2;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    cnt = 0;
    repeat (80) begin
      tick();
      if (new_sample || busy) cnt++;
    end
    check("t5_idle_done_ignored", cnt, 0);
    check("t5_idle_temp", temp_raw, 16'h0550);
    pulse_req();
    wait_sig(0, 20, n, hit);
    send_done(v2);
    repeat (10) tick();
    send_done(72'd0);
    wait_sig(1, 100, n, hit);
    check("t5_check_done_ignored", n, 55);
    check("t5_temp", temp_raw, 16'h0191);
    check("t5_cnt", sample_cnt, 6);
    pulse_req();
    wait_sig(0, 20, n, hit);
    send_done(v1);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_flags", {eng_rst, eng_start, busy, temp_valid, new_sample, crc_err, timeout_err}, 32'b1000000);
    check("t6_rst_temp", temp_raw, 0);
    check("t6_rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;
    repeat (100) tick();
    check("t6_abort_idle", {busy, new_sample, eng_start}, 0);
    force dut.sample_cnt_q = 16'hFFFF;
    tick();
    release dut.sample_cnt_q;
    tick();
    check("t6_preload", sample_cnt, 16'hFFFF);
    pulse_req();
    wait_sig(0, 20, n, hit);
    send_done(v1);
    wait_sig(1, 100, n, hit);
    check("t6_latency", n, 66);
    check("t6_cnt_wrap", sample_cnt, 0);
    check("t6_temp", temp_raw, 16'h0550);
    check("t6_valid", temp_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
